// File: rtl/ram_block_requester_pkg.sv
// Shared types for the RAM block requester: RAM handshake states, requester FSM states,
// block owner encoding and the round-robin grant helper.
package ram_block_requester_pkg;

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} req_state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  // A lone request wins outright; on contention the side not granted last time wins.
  function automatic owner_t rr_pick(input logic i_req, input logic d_req, input owner_t last);
    if (i_req && d_req) return (last == OWN_I) ? OWN_D : OWN_I;
    return d_req ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/ram_block_requester.sv
// Initiator side of cpu_ram_if: arbitrates icache/dcache block requests and sequences each
// block as back-to-back single-word RAM accesses. Optional per-word timeout: RAM_REQ_TIMEOUT_EN.
module ram_block_requester
  import ram_block_requester_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 2,
  parameter int IDX_W           = 1
`ifdef RAM_REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT         = 64
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  input  logic             d_req,
  input  logic             d_wen,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_store,
  output logic             blk_owner,
  output logic             blk_busy,
  output logic [IDX_W-1:0] blk_idx,
  output logic             blk_word_vld,
  output logic [31:0]      blk_load,
  output logic             i_done,
  output logic             d_done,
  output logic             ram_err,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate,
  output req_state_t       dbg_state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  req_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_q, last_d;
  logic [31:0]      base_q, base_d;
  logic             wen_q, wen_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  owner_t           grant;

`ifdef RAM_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      last_q  <= OWN_I;
      base_q  <= '0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
`ifdef RAM_REQ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      base_q  <= base_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
`ifdef RAM_REQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    base_d  = base_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    err_d   = err_q;
    grant   = rr_pick(i_req, d_req, last_q);
`ifdef RAM_REQ_TIMEOUT_EN
    tmo_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant;
          base_d  = (grant == OWN_D) ? d_addr : i_addr;
          wen_d   = (grant == OWN_D) && d_wen;
          idx_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ramstate == ACCESS) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end else if (ramstate == ERROR) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
`ifdef RAM_REQ_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      DONE: begin
        last_d  = owner_q;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables drop in DONE and IDLE, so every block starts from a fresh RAM request.
  always_comb begin
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    blk_word_vld = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    if (state_q == XFER) begin
      ramREN       = !wen_q;
      ramWEN       = wen_q;
      ramaddr      = base_q + 32'({idx_q, 2'b00});
      ramstore     = (wen_q && owner_q == OWN_D) ? d_store : '0;
      blk_word_vld = (ramstate == ACCESS);
    end
    if (state_q == DONE) begin
      i_done = (owner_q == OWN_I);
      d_done = (owner_q == OWN_D);
    end
  end

  assign blk_owner   = owner_q;
  assign blk_busy    = (state_q != IDLE);
  assign blk_idx     = idx_q;
  assign blk_load    = ramload;
  assign ram_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_block_requester.sv
// Bench for ram_block_requester: variable-latency RAM model, random block traffic checked
// against a word-level reference memory through an expected-response scoreboard.
module tb_ram_block_requester;
  import ram_block_requester_pkg::*;

  localparam int WPB   = 2;
  localparam int IDX_W = 1;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             i_req, d_req, d_wen;
  logic [31:0]      i_addr, d_addr, d_store;
  logic             blk_owner, blk_busy, blk_word_vld, i_done, d_done, ram_err;
  logic [IDX_W-1:0] blk_idx;
  logic [31:0]      blk_load;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;
  req_state_t       dbg_state;

  ram_block_requester #(.WORDS_PER_BLOCK(WPB), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .blk_owner(blk_owner), .blk_busy(blk_busy), .blk_idx(blk_idx),
    .blk_word_vld(blk_word_vld), .blk_load(blk_load),
    .i_done(i_done), .d_done(d_done), .ram_err(ram_err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0007);
  endfunction

  // RAM model: ACCESS once a request has been held ram_lat+2 cycles at the same address.
  logic [31:0] ram_mem [0:255];
  bit          ram_inited = 1'b0;
  int          ram_lat;
  int          ram_mode;   // 0 normal, 1 stuck BUSY, 2 ERROR
  logic        en_q = 1'b0;
  logic [31:0] addr_q = '0;
  int          w_q = 0;
  int          w;

  always_comb begin
    w        = 0;
    ramstate = FREE;
    ramload  = '0;
    if (ramREN || ramWEN) begin
      w = (en_q && ramaddr == addr_q) ? w_q + 1 : 1;
      if (ram_mode == 2) ramstate = ERROR;
      else if (ram_mode == 0 && w >= ram_lat + 2) begin
        ramstate = ACCESS;
        if (ramREN) ramload = ram_mem[ramaddr[9:2]];
      end else ramstate = BUSY;
    end
  end

  always @(posedge CLK) begin
    en_q   <= ramREN || ramWEN;
    addr_q <= ramaddr;
    w_q    <= w;
    if (!ram_inited) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
      ram_inited <= 1'b1;
    end else if (ramstate == ACCESS && ramWEN) begin
      ram_mem[ramaddr[9:2]] <= ramstore;
    end
  end

  // dcache side: write data selected by the word index the requester is on.
  logic [31:0] dw0, dw1;
  always_comb d_store = (blk_idx == 1'b1) ? dw1 : dw0;

  // Reference model: word memory plus expected per-word and per-block responses.
  logic [31:0] ref_mem [0:255];
  logic [65:0] exp_q[$];   // {wr, owner, addr, data}
  logic [0:0]  done_q[$];  // owner of each finished block
  logic        m_last;

  task automatic model_block(input logic own, input logic wr, input logic [31:0] base);
    logic [31:0] a, d;
    for (int k = 0; k < WPB; k++) begin
      a = base + 32'(4 * k);
      if (wr) begin
        d = (k == 0) ? dw0 : dw1;
        ref_mem[a[9:2]] = d;
      end else d = ref_mem[a[9:2]];
      exp_q.push_back({wr, own, a, d});
    end
    done_q.push_back(own);
    m_last = own;
  endtask

  // Monitor: pops an expectation whenever the DUT completes a word or a block.
  logic [65:0] mon_e;
  logic [0:0]  mon_d;
  always @(negedge CLK) begin
    if (nRST) begin
      if (ramREN && ramWEN) begin
        errors++;
        $display("FAIL en_exclusive: got REN=1 WEN=1 expected at most one");
      end
      if (blk_word_vld) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_unexpected: got addr %h expected no word", ramaddr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", {ramWEN, blk_owner, ramaddr, ramWEN ? ramstore : blk_load}, mon_e);
        end
      end
      if (i_done || d_done) begin
        if (done_q.size() == 0 || (i_done && d_done)) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got i_done=%0b d_done=%0b expected none", i_done, d_done);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_owner", {65'd0, d_done}, {65'd0, mon_d});
        end
      end
    end
  end

  task automatic run_pair(input logic do_i, input logic [31:0] ia, input logic do_d,
                          input logic dwr, input logic [31:0] da);
    logic first_d;
    @(negedge CLK);
    i_req = do_i; i_addr = ia; d_req = do_d; d_wen = dwr; d_addr = da;
    first_d = do_d && (!do_i || m_last == 1'b0);
    if (first_d) begin
      model_block(1'b1, dwr, da);
      if (do_i) model_block(1'b0, 1'b0, ia);
    end else begin
      if (do_i) model_block(1'b0, 1'b0, ia);
      if (do_d) model_block(1'b1, dwr, da);
    end
    for (int c = 0; c < 400 && (i_req || d_req); c++) begin
      @(negedge CLK);
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
    end
    if (i_req || d_req) begin
      checks++; errors++;
      $display("FAIL pair_timeout: got no done within 400 cycles expected done");
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic single_abort(input string name, input int mode, input int exp_cycles);
    int elapsed;
    ram_mode = mode;
    elapsed  = -1;
    @(negedge CLK);
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h300;
    done_q.push_back(1'b1);
    m_last = 1'b1;
    for (int c = 1; c < 200 && elapsed < 0; c++) begin
      @(negedge CLK);
      if (d_done) begin elapsed = c; d_req = 1'b0; end
    end
    d_req = 1'b0;
    ram_mode = 0;
    chk({name, "_cycles"}, 66'(elapsed), 66'(exp_cycles));
    chk({name, "_ram_err"}, {65'd0, ram_err}, 66'd1);
  endtask

  logic [21:0] vld_m, en_m, done_m;
  int          addr_errs;

  initial begin
    nRST = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    i_addr = '0; d_addr = '0; dw0 = '0; dw1 = '0;
    ram_lat = 2; ram_mode = 0; m_last = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge CLK);
    chk("reset_ctrl", {56'd0, blk_owner, blk_busy, blk_idx, blk_word_vld, i_done, d_done,
                       ram_err, ramREN, ramWEN, dbg_state}, 66'd0);
    chk("reset_data", {2'd0, ramaddr, ramstore}, 66'd0);
    nRST = 1'b1;

    // Same block read twice with the request held across the first done.
    model_block(1'b0, 1'b0, 32'h100);
    model_block(1'b0, 1'b0, 32'h100);
    addr_errs = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge CLK);
      vld_m[k]  = blk_word_vld;
      en_m[k]   = ramREN | ramWEN;
      done_m[k] = i_done;
      if (ramREN && (ramaddr != ((k < 5 || (k > 10 && k < 15)) ? 32'h100 : 32'h104))) addr_errs++;
      if (k == 0) begin i_req = 1'b1; i_addr = 32'h100; end
      if (k == 19) i_req = 1'b0;
    end
    chk("lat_word_vld", {44'd0, vld_m}, 66'h44110);
    chk("lat_enables", {44'd0, en_m}, 66'h7F9FE);
    chk("lat_done", {44'd0, done_m}, 66'h80200);
    chk("lat_addr_seq", 66'(addr_errs), 66'd0);

    // Writeback then readback of the same block.
    dw0 = 32'hA; dw1 = 32'hB;
    run_pair(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    chk("wb_ram_word0", {34'd0, ram_mem[128]}, 66'hA);
    chk("wb_ram_word1", {34'd0, ram_mem[129]}, 66'hB);
    run_pair(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);

    // Contention: round-robin order is checked by the scoreboard.
    run_pair(1'b1, 32'h040, 1'b1, 1'b0, 32'h080);
    run_pair(1'b1, 32'h0C0, 1'b1, 1'b1, 32'h0C0);

    for (int n = 0; n < 40; n++) begin
      logic di, dd;
      ram_lat = $urandom_range(0, 3);
      dw0 = $urandom; dw1 = $urandom;
      di = 1'($urandom_range(0, 1));
      dd = di ? 1'($urandom_range(0, 1)) : 1'b1;
      run_pair(di, 32'($urandom_range(0, 127)) << 3, dd, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 127)) << 3);
    end
    ram_lat = 2;
    chk("no_err_before_abort", {65'd0, ram_err}, 66'd0);

    single_abort("error_abort", 2, 2);
`ifdef RAM_REQ_TIMEOUT_EN
    single_abort("timeout_abort", 1, 65);
`endif
    run_pair(1'b1, 32'h010, 1'b0, 1'b0, 32'h0);
    chk("ram_err_sticky", {65'd0, ram_err}, 66'd1);

    // Asynchronous reset while word 1 of a block is outstanding.
    @(negedge CLK);
    i_req = 1'b1; i_addr = 32'h140;
    model_block(1'b0, 1'b0, 32'h140);
    for (int c = 0; c < 50 && !(blk_busy && blk_idx == 1'b1); c++) @(negedge CLK);
    @(negedge CLK);
    chk("pre_reset_word1", {64'd0, blk_busy, blk_idx}, 66'd3);
    nRST = 1'b0;
    #1;
    chk("async_reset_outs", {59'd0, ramREN, ramWEN, blk_busy, blk_word_vld, i_done, d_done,
                             ram_err}, 66'd0);
    i_req = 1'b0;
    exp_q.delete(); done_q.delete();
    m_last = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    run_pair(1'b1, 32'h140, 1'b0, 1'b0, 32'h0);
    run_pair(1'b1, 32'h180, 1'b1, 1'b0, 32'h1C0);

    repeat (4) @(negedge CLK);
    chk("queues_drained", 66'(exp_q.size() + done_q.size()), 66'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
